// File: rtl/fp_pkg.sv
// Shared definitions for the FP-to-integer converter: format derivation,
// FSM state encoding and operand classification.
package fp_pkg;

    function automatic int fp_exponent(input int size);
        return 5 + ($clog2(size) - 4) * 3;
    endfunction

    function automatic int fp_fraction(input int size);
        return size - fp_exponent(size) - 1;
    endfunction

    function automatic int fp_bias(input int size);
        return (1 << (fp_exponent(size) - 1)) - 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ROUND,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

endpackage

// File: rtl/fp_to_int_align_shifter.sv
// Combinational bidirectional alignment of the mantissa by the signed unbiased
// exponent, producing the integer magnitude plus guard and sticky bits.
module align_shifter #(
    parameter int EXPONENT  = 11,
    parameter int FRACTION  = 52,
    parameter int INT_WIDTH = 64
) (
    input  logic [FRACTION:0]        mantissa,
    input  logic signed [EXPONENT:0] exponent,
    input  logic                     is_zero,
    output logic [INT_WIDTH:0]       mag,
    output logic                     guard,
    output logic                     sticky,
    output logic                     clamp
);
    localparam int MW = FRACTION + 1;

    int                 ev;
    logic [INT_WIDTH:0] wide_m;
    logic [2*MW-1:0]    frame;

    assign ev     = int'(exponent);
    assign wide_m = (INT_WIDTH + 1)'(mantissa);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        clamp  = 1'b0;
        frame  = '0;
        if (is_zero) begin
            mag = '0;
        end else if (ev >= FRACTION) begin
            if (ev >= INT_WIDTH) begin
                clamp = 1'b1;
                mag   = wide_m << (INT_WIDTH - FRACTION);
            end else begin
                mag = wide_m << (ev - FRACTION);
            end
        end else if (ev >= 0) begin
            // Lower half of the frame catches the shifted-out bits, MSB first.
            frame  = {mantissa, {MW{1'b0}}} >> (FRACTION - ev);
            mag    = (INT_WIDTH + 1)'(frame[2*MW-1:MW]);
            guard  = frame[MW-1];
            sticky = |frame[MW-2:0];
        end else if (ev == -1) begin
            guard  = 1'b1;
            sticky = |mantissa[FRACTION-1:0];
        end else begin
            sticky = 1'b1;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// Multi-cycle floating-point to signed integer converter with round-to-nearest-even,
// saturation and exception flags; one operand in flight behind a valid/ready handshake.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int SIZE      = 64,
    parameter int EXPONENT  = fp_exponent(SIZE),
    parameter int FRACTION  = fp_fraction(SIZE),
    parameter int BIAS      = fp_bias(SIZE),
    parameter int INT_WIDTH = SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE-1:0]      i_number,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INT_WIDTH-1:0] o_result,
    output logic                 o_invalid,
    output logic                 o_overflow,
    output logic                 o_inexact
);
    typedef struct packed {
        logic                     sign;
        logic signed [EXPONENT:0] exponent;
        logic [FRACTION:0]        mantissa;
    } fields_t;

    localparam logic [INT_WIDTH:0]   MAG_POS_MAX = {2'b00, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH:0]   MAG_NEG_MAX = {2'b01, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] INT_MAX     = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN     = {1'b1, {(INT_WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic [SIZE-1:0]    number_q;
    fields_t            fields_q, fields_d;
    fp_class_t          cls_q, cls_d;
    logic [INT_WIDTH:0] mag_q, mag_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               clamp_q, clamp_d;

    logic [EXPONENT-1:0] exp_field;
    logic [FRACTION-1:0] frac_field;

    assign exp_field  = number_q[SIZE-2 -: EXPONENT];
    assign frac_field = number_q[FRACTION-1:0];

    always_comb begin
        fields_d.sign     = number_q[SIZE-1];
        fields_d.exponent = (EXPONENT + 1)'({1'b0, exp_field}) - (EXPONENT + 1)'(BIAS);
        fields_d.mantissa = {1'b1, frac_field};
        if (&exp_field) begin
            cls_d = (|frac_field) ? CLS_NAN : CLS_INF;
        end else if (exp_field == '0) begin
            cls_d = CLS_ZERO;
        end else begin
            cls_d = CLS_NORMAL;
        end
    end

    align_shifter #(
        .EXPONENT (EXPONENT),
        .FRACTION (FRACTION),
        .INT_WIDTH(INT_WIDTH)
    ) u_align (
        .mantissa(fields_q.mantissa),
        .exponent(fields_q.exponent),
        .is_zero (cls_q == CLS_ZERO),
        .mag     (mag_d),
        .guard   (guard_d),
        .sticky  (sticky_d),
        .clamp   (clamp_d)
    );

    logic [INT_WIDTH:0]   mag_rnd, mag_neg;
    logic                 is_nan, is_inf, ovf_d, inexact_d;
    logic [INT_WIDTH-1:0] result_d;

    always_comb begin
        mag_rnd = mag_q + (INT_WIDTH + 1)'(guard_q & (sticky_q | mag_q[0]));
        mag_neg = ~mag_rnd + 1'b1;
        is_nan  = (cls_q == CLS_NAN);
        is_inf  = (cls_q == CLS_INF);
        ovf_d   = is_inf
                | ((cls_q == CLS_NORMAL)
                   & (clamp_q
                      | (!fields_q.sign && mag_rnd > MAG_POS_MAX)
                      | ( fields_q.sign && mag_rnd > MAG_NEG_MAX)));
        inexact_d = (guard_q | sticky_q) & ~(is_nan | is_inf | ovf_d);
        if (is_nan) begin
            result_d = INT_MAX;
        end else if (ovf_d) begin
            result_d = fields_q.sign ? INT_MIN : INT_MAX;
        end else begin
            result_d = fields_q.sign ? mag_neg[INT_WIDTH-1:0] : mag_rnd[INT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (i_valid) state_next = ST_UNPACK;
            ST_UNPACK: state_next = ST_ALIGN;
            ST_ALIGN:  state_next = ST_ROUND;
            ST_ROUND:  state_next = ST_DONE;
            ST_DONE:   if (i_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_result   <= '0;
            o_invalid  <= 1'b0;
            o_overflow <= 1'b0;
            o_inexact  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_ROUND) begin
                o_result   <= result_d;
                o_invalid  <= is_nan;
                o_overflow <= ovf_d;
                o_inexact  <= inexact_d;
            end
        end
    end

    // NOTE: pipeline datapath registers carry no reset; the FSM state alone
    // decides when their contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && i_valid) number_q <= i_number;
        if (state == ST_UNPACK) begin
            fields_q <= fields_d;
            cls_q    <= cls_d;
        end
        if (state == ST_ALIGN) begin
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            clamp_q  <= clamp_d;
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int at SIZE=64: directed test-plan vectors,
// handshake/reset scenarios, and random operands against a real-arithmetic model.
module tb_fp_to_int;
    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
    localparam real         TWO63   = 9223372036854775808.0;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_number = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_result;
    logic        o_invalid;
    logic        o_overflow;
    logic        o_inexact;

    int errors = 0;
    int checks = 0;

    fp_to_int dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_number  (i_number),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_invalid (o_invalid),
        .o_overflow(o_overflow),
        .o_inexact (o_inexact)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value-level conversion using real arithmetic on the decoded double.
    function automatic void model(input logic [63:0] n, output logic [63:0] r,
                                  output logic inv, output logic ovf, output logic inx);
        logic [10:0] ex;
        real         a, t, f;
        longint      ti;
        ex = n[62:52];
        r = '0; inv = 1'b0; ovf = 1'b0; inx = 1'b0;
        if (ex == 11'h7FF) begin
            if (n[51:0] != '0) begin
                inv = 1'b1;
                r   = INT_MAX;
            end else begin
                ovf = 1'b1;
                r   = n[63] ? INT_MIN : INT_MAX;
            end
        end else if (ex != 11'h000) begin
            a = $bitstoreal({1'b0, n[62:0]});
            if (a >= TWO63) begin
                if (n[63] && a == TWO63) begin
                    r = INT_MIN;
                end else begin
                    ovf = 1'b1;
                    r   = n[63] ? INT_MIN : INT_MAX;
                end
            end else begin
                t  = $floor(a);
                f  = a - t;
                ti = longint'(t);
                if (f > 0.5 || (f == 0.5 && ti[0])) ti++;
                inx = (f != 0.0);
                r   = n[63] ? 64'(-ti) : 64'(ti);
            end
        end
    endfunction

    // Drives one operand, waits (bounded) for the result, compares, then consumes it.
    task automatic convert(input string tag, input logic [63:0] n, input logic [63:0] exp_r,
                           input logic exp_inv, input logic exp_ovf, input logic exp_inx,
                           input bit chk_ovf, input bit chk_lat);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        while (!o_ready && wait_cnt < 20) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        i_valid  = 1'b1;
        i_number = n;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, o_result, exp_r);
        check({tag, "_invalid"}, 64'(o_invalid), 64'(exp_inv));
        if (chk_ovf) check({tag, "_overflow"}, 64'(o_overflow), 64'(exp_ovf));
        check({tag, "_inexact"}, 64'(o_inexact), 64'(exp_inx));
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] n, er;
        logic        ei, eo, ex;
        int          wait_cnt;

        // Reset state
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);
        check("reset_result", o_result, 64'd0);
        check("reset_flags", {61'd0, o_invalid, o_overflow, o_inexact}, 64'd0);

        // Directed vectors
        convert("one",      64'h3FF0_0000_0000_0000, 64'd1,                   0, 0, 0, 1, 1);
        convert("neg2p5",   64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 1, 1);
        convert("3p5",      64'h400C_0000_0000_0000, 64'd4,                   0, 0, 1, 1, 0);
        convert("half",     64'h3FE0_0000_0000_0000, 64'd0,                   0, 0, 1, 1, 0);
        convert("denormal", 64'h0000_0000_0000_0001, 64'd0,                   0, 0, 0, 1, 0);
        convert("pos2p63",  64'h43E0_0000_0000_0000, INT_MAX,                 0, 1, 0, 1, 0);
        convert("neg2p63",  64'hC3E0_0000_0000_0000, INT_MIN,                 0, 0, 0, 1, 0);
        convert("nan",      64'h7FF8_0000_0000_0000, INT_MAX,                 1, 0, 0, 0, 0);
        convert("neginf",   64'hFFF0_0000_0000_0000, INT_MIN,                 0, 1, 0, 1, 0);

        // Backpressure: hold result in DONE, ignore a second operand
        i_valid  = 1'b1;
        i_number = 64'h400C_0000_0000_0000;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_cnt = 1;
        while (!o_valid && wait_cnt < 20) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_result", o_result, 64'd4);
            check("bp_ready", 64'(o_ready), 64'd0);
            i_valid  = (c == 3);
            i_number = 64'h3FF0_0000_0000_0000;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("bp_no_second", 64'(o_valid), 64'd0);
            @(negedge i_clk);
        end

        // Reset while in ALIGN drops the operand
        i_valid  = 1'b1;
        i_number = 64'h4059_0000_0000_0000;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_align_valid", 64'(o_valid), 64'd0);
        check("rst_align_ready", 64'(o_ready), 64'd1);
        check("rst_align_result", o_result, 64'd0);
        check("rst_align_flags", {61'd0, o_invalid, o_overflow, o_inexact}, 64'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            check("rst_align_silent", 64'(o_valid), 64'd0);
        end

        // Random operands around the rounding and saturation boundaries
        for (int k = 0; k < 60; k++) begin
            n[63]    = 1'($urandom);
            n[62:52] = (k % 10 == 0) ? 11'd0 : 11'($urandom_range(1020, 1088));
            n[51:0]  = 52'({$urandom, $urandom});
            if (k % 2 == 1) n[39:0] = '0;
            model(n, er, ei, eo, ex);
            convert($sformatf("rand%0d", k), n, er, ei, eo, ex, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
